// File: rtl/red_pitaya_daisy_pkg.sv
// Shared daisy-chain link definitions: training word, default timing constants and
// the link-controller state encoding with its output decode.
package red_pitaya_daisy_pkg;

  localparam logic [15:0] DAISY_TRAIN_WORD = 16'h00FF;

  localparam int DAISY_SETTLE_CYC = 256;
  localparam int DAISY_TRAIN_TMO  = 50000;
  localparam int DAISY_RETRY_MAX  = 8;
  localparam int DAISY_FILT       = 4;
  localparam int DAISY_TMR_W      = 20;
  localparam int DAISY_RETRY_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_TRAIN  = 3'd3,
    ST_LOCK   = 3'd4,
    ST_UP     = 3'd5,
    ST_FAIL   = 3'd6
  } link_state_e;

  typedef struct packed {
    logic rx_en;
    logic rx_train;
    logic tx_train;
    logic link_up;
    logic link_err;
  } link_outs_t;

  function automatic link_outs_t link_state_outs(input link_state_e st);
    link_outs_t o;
    o = '0;
    case (st)
      ST_RESET:  o.tx_train = 1'b1;
      ST_SETTLE: begin o.rx_en = 1'b1; o.tx_train = 1'b1; end
      ST_TRAIN:  begin o.rx_en = 1'b1; o.rx_train = 1'b1; o.tx_train = 1'b1; end
      ST_LOCK:   begin o.rx_en = 1'b1; o.tx_train = 1'b1; end
      ST_UP:     begin o.rx_en = 1'b1; o.link_up = 1'b1; end
      ST_FAIL:   o.link_err = 1'b1;
      default:   o = '0;
    endcase
    return o;
  endfunction

  function automatic logic is_train_word(input logic [15:0] word);
    return word == DAISY_TRAIN_WORD;
  endfunction

endpackage

// File: rtl/red_pitaya_daisy_link_ctrl_if.sv
// Control/status and TX/RX handshake bundle of the daisy link controller.
// Stat counters exist only when DAISY_LINK_STATS_EN is defined.
interface red_pitaya_daisy_link_ctrl_if;

  logic       ctrl_en_i;
  logic       ctrl_auto_i;
  logic       ctrl_start_i;
  logic       rx_trained_i;
  logic       rx_en_o;
  logic       rx_train_o;
  logic       tx_train_o;
  logic       link_up_o;
  logic       link_err_o;
  logic [2:0] state_o;
  logic [3:0] retry_cnt_o;
`ifdef DAISY_LINK_STATS_EN
  logic [15:0] stat_retrain_o;
  logic [15:0] stat_loss_o;
`endif

  modport master (
`ifdef DAISY_LINK_STATS_EN
    output stat_retrain_o, stat_loss_o,
`endif
    input  ctrl_en_i, ctrl_auto_i, ctrl_start_i, rx_trained_i,
    output rx_en_o, rx_train_o, tx_train_o, link_up_o, link_err_o,
    output state_o, retry_cnt_o
  );

  modport slave (
`ifdef DAISY_LINK_STATS_EN
    input  stat_retrain_o, stat_loss_o,
`endif
    output ctrl_en_i, ctrl_auto_i, ctrl_start_i, rx_trained_i,
    input  rx_en_o, rx_train_o, tx_train_o, link_up_o, link_err_o,
    input  state_o, retry_cnt_o
  );

endinterface

// File: rtl/red_pitaya_daisy_sync.sv
// Two-flop synchronizer for a single level signal crossing into the clk domain.
module red_pitaya_daisy_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // NOTE: sequential state uses non-blocking (<=) so both flops sample the old values on the same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/red_pitaya_daisy_link_ctrl.sv
// Daisy-chain link sequencer: RX reset/settle, training with timeout and retries, link-up monitor.
// Define DAISY_LINK_STATS_EN to add the saturating retrain/loss statistic counters.
module red_pitaya_daisy_link_ctrl
  import red_pitaya_daisy_pkg::*;
#(
  parameter int SETTLE_CYC = DAISY_SETTLE_CYC,
  parameter int TRAIN_TMO  = DAISY_TRAIN_TMO,
  parameter int RETRY_MAX  = DAISY_RETRY_MAX,
  parameter int FILT       = DAISY_FILT,
  parameter int TMR_W      = DAISY_TMR_W
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  red_pitaya_daisy_link_ctrl_if.master link
);

  localparam int FILT_W = $clog2(FILT + 1);

  link_state_e              r_state;
  link_state_e              w_state_nxt;
  logic [TMR_W-1:0]         r_timer;
  logic [FILT_W-1:0]        r_filt;
  logic [DAISY_RETRY_W-1:0] r_retry;
  logic [DAISY_RETRY_W-1:0] w_retry_nxt;
  link_outs_t               r_outs;

  logic w_synced;
  logic w_restart;
  logic w_clr;
  logic w_settle_done;
  logic w_train_tmo;
  logic w_filt_match;
  logic w_filt_done;

  red_pitaya_daisy_sync u_sync (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_d   (link.rx_trained_i),
    .o_q   (w_synced)
  );

  assign w_settle_done = (r_timer == TMR_W'(SETTLE_CYC - 1));
  assign w_train_tmo   = (r_timer == TMR_W'(TRAIN_TMO - 1));

  // TRAIN waits for the trained flag to rise, UP watches for it to fall.
  assign w_filt_match  = ((r_state == ST_TRAIN) &&  w_synced) ||
                         ((r_state == ST_UP)    && !w_synced);
  assign w_filt_done   = w_filt_match && (r_filt == FILT_W'(FILT - 1));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    w_restart   = 1'b0;
    if (!link.ctrl_en_i) begin
      w_state_nxt = ST_IDLE;
    end else if (r_state == ST_IDLE) begin
      if (link.ctrl_start_i || link.ctrl_auto_i) begin
        w_state_nxt = ST_RESET;
        w_retry_nxt = '0;
      end
    end else if (link.ctrl_start_i) begin
      w_state_nxt = ST_RESET;
      w_retry_nxt = '0;
      w_restart   = 1'b1;
    end else begin
      case (r_state)
        ST_RESET:  if (w_settle_done) w_state_nxt = ST_SETTLE;
        ST_SETTLE: if (w_settle_done) w_state_nxt = ST_TRAIN;
        ST_TRAIN: begin
          if (w_filt_done) begin
            w_state_nxt = ST_LOCK;
          end else if (w_train_tmo) begin
            if (r_retry == DAISY_RETRY_W'(RETRY_MAX)) begin
              w_state_nxt = ST_FAIL;
            end else begin
              w_state_nxt = ST_RESET;
              if (r_retry != '1) w_retry_nxt = r_retry + DAISY_RETRY_W'(1);
            end
          end
        end
        ST_LOCK:   if (w_settle_done) w_state_nxt = ST_UP;
        ST_UP: begin
          if (w_filt_done) begin
            if (link.ctrl_auto_i) begin
              w_state_nxt = ST_RESET;
              w_retry_nxt = '0;
            end else begin
              w_state_nxt = ST_FAIL;
            end
          end
        end
        ST_FAIL:   w_state_nxt = ST_FAIL;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // A forced restart re-enters RESET, so it must rewind the timer like a real state change.
  assign w_clr = w_restart || (w_state_nxt != r_state);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_retry <= '0;
      r_timer <= '0;
      r_filt  <= '0;
      r_outs  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_retry <= w_retry_nxt;
      r_outs  <= link_state_outs(w_state_nxt);
      if (w_clr)                r_timer <= '0;
      else if (r_timer != '1)   r_timer <= r_timer + TMR_W'(1);
      if (w_clr || !w_filt_match) r_filt <= '0;
      else                        r_filt <= r_filt + FILT_W'(1);
    end
  end

  assign link.rx_en_o     = r_outs.rx_en;
  assign link.rx_train_o  = r_outs.rx_train;
  assign link.tx_train_o  = r_outs.tx_train;
  assign link.link_up_o   = r_outs.link_up;
  assign link.link_err_o  = r_outs.link_err;
  assign link.state_o     = r_state;
  assign link.retry_cnt_o = r_retry;

`ifdef DAISY_LINK_STATS_EN
  logic [15:0] r_stat_retrain;
  logic [15:0] r_stat_loss;
  logic        w_loss;
  logic        w_retrain;

  // A loss only counts when it actually drives the transition (not pre-empted by disable or start).
  assign w_loss    = link.ctrl_en_i && !link.ctrl_start_i && (r_state == ST_UP) && w_filt_done;
  assign w_retrain = (r_state == ST_UP) && (w_state_nxt == ST_RESET);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stat_retrain <= '0;
      r_stat_loss    <= '0;
    end else begin
      if (w_retrain && (r_stat_retrain != '1)) r_stat_retrain <= r_stat_retrain + 16'd1;
      if (w_loss && (r_stat_loss != '1))       r_stat_loss    <= r_stat_loss + 16'd1;
    end
  end

  assign link.stat_retrain_o = r_stat_retrain;
  assign link.stat_loss_o    = r_stat_loss;
`endif

endmodule

// File: tb/tb_red_pitaya_daisy_link_ctrl.sv
// Self-checking bench: expected link behaviour is a timeline of (state, retry, length)
// segments derived from the sequencing rules, compared every cycle against the DUT.
`timescale 1ns/1ps
module tb_red_pitaya_daisy_link_ctrl;

  localparam int S        = 32;
  localparam int TMO      = 128;
  localparam int RMAX     = 2;
  localparam int FILT     = 4;
  localparam int SYNC_LAT = 2;

  localparam int IDLE = 0, RESET = 1, SETTLE = 2, TRAIN = 3, LOCK = 4, UP = 5, FAIL = 6;

  typedef struct {
    int st;
    int retry;
    int len;
  } seg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   k;
  int   d, g, j, m;
  seg_t sched[$];

  red_pitaya_daisy_link_ctrl_if lif ();

  red_pitaya_daisy_link_ctrl #(
    .SETTLE_CYC (S),
    .TRAIN_TMO  (TMO),
    .RETRY_MAX  (RMAX),
    .FILT       (FILT),
    .TMR_W      (20)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .link  (lif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, want);
    end
  endtask

  // {rx_en, rx_train, tx_train, link_up, link_err} for each state.
  function automatic logic [4:0] exp_outs(input int st);
    case (st)
      RESET:   return 5'b00100;
      SETTLE:  return 5'b10100;
      TRAIN:   return 5'b11100;
      LOCK:    return 5'b10100;
      UP:      return 5'b10010;
      FAIL:    return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic new_sched();
    sched.delete();
    k = 0;
  endtask

  task automatic add(input int st, input int retry, input int len);
    seg_t s;
    s.st = st; s.retry = retry; s.len = len;
    sched.push_back(s);
  endtask

  function automatic void exp_at(input int kk, output int st, output int rt);
    int acc;
    acc = 0;
    st  = -1;
    rt  = -1;
    foreach (sched[i]) begin
      st = sched[i].st;
      rt = sched[i].retry;
      if (sched[i].len < 0 || kk <= acc + sched[i].len) return;
      acc += sched[i].len;
    end
  endfunction

  task automatic observe(input int n);
    int st, rt;
    repeat (n) begin
      @(negedge clk);
      k++;
      exp_at(k, st, rt);
      check("state", lif.state_o, st);
      check("outs", {lif.rx_en_o, lif.rx_train_o, lif.tx_train_o, lif.link_up_o, lif.link_err_o},
            exp_outs(st));
      check("retry", lif.retry_cnt_o, rt);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"}, lif.state_o, 0);
    check({tag, "_outs"}, {lif.rx_en_o, lif.rx_train_o, lif.tx_train_o, lif.link_up_o, lif.link_err_o}, 0);
    check({tag, "_retry"}, lif.retry_cnt_o, 0);
`ifdef DAISY_LINK_STATS_EN
    check({tag, "_stat_retrain"}, lif.stat_retrain_o, 0);
    check({tag, "_stat_loss"}, lif.stat_loss_o, 0);
`endif
  endtask

  initial begin
    k = 0;
    lif.ctrl_en_i    = 1'b0;
    lif.ctrl_auto_i  = 1'b0;
    lif.ctrl_start_i = 1'b0;
    lif.rx_trained_i = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Enabled without start or auto: stays idle.
    lif.ctrl_en_i = 1'b1;
    new_sched(); add(IDLE, 0, -1);
    observe(4);

    // Start pulse, trained rises d cycles after the last settle cycle.
    d = $urandom_range(0, TMO - SYNC_LAT - FILT);
    lif.ctrl_start_i = 1'b1;
    new_sched();
    add(RESET, 0, S); add(SETTLE, 0, S); add(TRAIN, 0, d + SYNC_LAT + FILT - 1);
    add(LOCK, 0, S); add(UP, 0, -1);
    observe(1);
    lif.ctrl_start_i = 1'b0;
    observe(2 * S - 1 + d);
    lif.rx_trained_i = 1'b1;
    observe(SYNC_LAT + FILT + S + 3);
    check("s1_link_up", lif.link_up_o, 1);
`ifdef DAISY_LINK_STATS_EN
    check("s1_stat_loss", lif.stat_loss_o, 0);
`endif

    // Auto mode: short glitch is filtered out.
    lif.ctrl_auto_i = 1'b1;
    g = $urandom_range(1, FILT - 1);
    new_sched(); add(UP, 0, -1);
    lif.rx_trained_i = 1'b0;
    observe(g);
    lif.rx_trained_i = 1'b1;
    observe(SYNC_LAT + FILT + 4);

    // Real loss re-trains; relock lands exactly on the timeout cycle (filter wins).
    d = TMO - SYNC_LAT - FILT + 1;
    new_sched();
    add(UP, 0, SYNC_LAT + FILT - 1); add(RESET, 0, S); add(SETTLE, 0, S);
    add(TRAIN, 0, d + SYNC_LAT + FILT - 1); add(LOCK, 0, S); add(UP, 0, -1);
    lif.rx_trained_i = 1'b0;
    observe(SYNC_LAT + FILT - 1 + 2 * S + d);
    lif.rx_trained_i = 1'b1;
    observe(SYNC_LAT + FILT + S + 3);
`ifdef DAISY_LINK_STATS_EN
    check("s3_stat_loss", lif.stat_loss_o, 1);
    check("s3_stat_retrain", lif.stat_retrain_o, 1);
`endif

    // Manual mode: loss goes to FAIL.
    lif.ctrl_auto_i = 1'b0;
    new_sched(); add(UP, 0, SYNC_LAT + FILT - 1); add(FAIL, 0, -1);
    lif.rx_trained_i = 1'b0;
    observe(SYNC_LAT + FILT + 5);
`ifdef DAISY_LINK_STATS_EN
    check("s4_stat_loss", lif.stat_loss_o, 2);
    check("s4_stat_retrain", lif.stat_retrain_o, 1);
`endif

    // Start from FAIL with trained stuck low: every window times out, then FAIL.
    lif.ctrl_start_i = 1'b1;
    new_sched();
    for (int i = 0; i <= RMAX; i++) begin
      add(RESET, i, S); add(SETTLE, i, S); add(TRAIN, i, TMO);
    end
    add(FAIL, RMAX, -1);
    observe(1);
    lif.ctrl_start_i = 1'b0;
    observe((RMAX + 1) * (2 * S + TMO) + 4);

    // Restart, one timeout, then disable together with start mid-TRAIN: disable wins, retry kept.
    j = $urandom_range(1, TMO);
    lif.ctrl_start_i = 1'b1;
    new_sched();
    add(RESET, 0, S); add(SETTLE, 0, S); add(TRAIN, 0, TMO);
    add(RESET, 1, S); add(SETTLE, 1, S); add(TRAIN, 1, j); add(IDLE, 1, -1);
    observe(1);
    lif.ctrl_start_i = 1'b0;
    observe(4 * S + TMO + j - 1);
    lif.ctrl_en_i    = 1'b0;
    lif.ctrl_start_i = 1'b1;
    observe(1);
    lif.ctrl_start_i = 1'b0;
    observe(4);

    // Asynchronous reset in the middle of SETTLE clears everything at once.
    m = $urandom_range(1, S - 1);
    lif.ctrl_en_i    = 1'b1;
    lif.ctrl_start_i = 1'b1;
    new_sched(); add(RESET, 0, S); add(SETTLE, 0, -1);
    observe(1);
    lif.ctrl_start_i = 1'b0;
    observe(S + m - 1);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    new_sched(); add(IDLE, 0, -1);
    observe(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
